// File: rtl/jpeg_enc_pingpong_ram_if.sv
// Producer/consumer signal bundle for the JPEG encoder ping-pong data-unit RAM.
// master = producer + consumer side, slave = the RAM.
interface jpeg_enc_pingpong_ram_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_commit;
  logic              wr_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              rd_avail;
  logic              rd_release;
  logic [1:0]        bank_full_cnt;
  logic              err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release,
    input  wr_ready, rd_data, rd_data_valid, rd_avail, bank_full_cnt, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release,
    output wr_ready, rd_data, rd_data_valid, rd_avail, bank_full_cnt, err
  );
endinterface

// File: rtl/jpeg_enc_pingpong_ram.sv
// Double-buffered data-unit RAM: producer fills one bank while the DCT reads the other.
// Banks move FREE -> FULL on commit and FULL -> FREE on release, consumed in commit order.
module jpeg_enc_pingpong_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 192,
  parameter int unsigned ADDR_W = 8
) (
  input logic                    clk,
  input logic                    reset_n,
  jpeg_enc_pingpong_ram_if.slave bus
);

  localparam logic [ADDR_W:0] DepthW = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [2][DEPTH];

  logic [1:0]        full_q, full_d;
  logic              wbank_q, wbank_d;
  logic              rbank_q, rbank_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;

  logic wr_ready, rd_avail;
  logic wr_addr_ok, rd_addr_ok;
  logic wr_ok, commit_ok, release_ok, rd_ok;

  assign wr_ready   = ~full_q[wbank_q];
  assign rd_avail   = full_q[rbank_q];
  assign wr_addr_ok = {1'b0, bus.wr_addr} < DepthW;
  assign rd_addr_ok = {1'b0, bus.rd_addr} < DepthW;
  assign wr_ok      = bus.wr_en & wr_ready & wr_addr_ok;
  assign commit_ok  = bus.wr_commit & wr_ready;
  assign release_ok = bus.rd_release & rd_avail;
  assign rd_ok      = bus.rd_en & rd_avail;

  always_comb begin
    full_d     = full_q;
    wbank_d    = wbank_q;
    rbank_d    = rbank_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = err_q;

    // Commit and release can only coincide on different banks: one is FREE, the other FULL.
    if (commit_ok) begin
      full_d[wbank_q] = 1'b1;
      wbank_d         = ~wbank_q;
    end
    if (release_ok) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
    end

    if (rd_ok) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_addr_ok ? mem[rbank_q][bus.rd_addr] : '0;
    end

    if ((bus.wr_en & ~(wr_ready & wr_addr_ok)) |
        (bus.wr_commit & ~wr_ready) |
        (bus.rd_en & ~(rd_avail & rd_addr_ok)) |
        (bus.rd_release & ~rd_avail)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q     <= 2'b00;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      full_q     <= full_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wbank_q][bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.wr_ready      = wr_ready;
  assign bus.rd_avail      = rd_avail;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_valid_q;
  assign bus.err           = err_q;
  assign bus.bank_full_cnt = {1'b0, full_q[0]} + {1'b0, full_q[1]};

endmodule

// File: doc/jpeg_enc_pingpong_ram.md
Name: jpeg_enc_pingpong_ram

Overview:
Parametrised double-buffered (ping-pong) data-unit RAM for the JPEG encoder pipeline.
- The producer side (colour conversion / DU fill) writes one bank while the consumer side (DCT) reads the other.
- Bank ownership passes by explicit commit/release handshakes.
- It replaces fixed single-bank DU storage and lets a fill and a DCT pass overlap.

Parameters:
DATA_W, 8, width of each stored word
DEPTH, 192, words per bank (one DU set, e.g. Y+U+V 3x64)
ADDR_W, 8, address width; must satisfy 2^ADDR_W >= DEPTH

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe into current write bank
wr_addr  in  ADDR_W  word address within write bank
wr_data  in  DATA_W  write data
wr_commit  in  1  producer marks current write bank full
wr_ready  out  1  current write bank is free and writable
rd_en  in  1  read strobe from current read bank
rd_addr  in  ADDR_W  word address within read bank
rd_data  out  DATA_W  registered read data
rd_data_valid  out  1  rd_data holds the result of the rd_en one cycle earlier
rd_avail  out  1  current read bank is full and readable
rd_release  in  1  consumer frees current read bank
bank_full_cnt  out  2  number of banks in FULL state (0..2)
err  out  1  sticky protocol error flag

Behaviour:
- Two banks of DEPTH x DATA_W storage. Each bank has a state bit: FREE or FULL.
- wbank pointer selects the write bank. rbank pointer selects the read bank.
- Reset (async, reset_n=0):
  - both banks FREE, wbank=0, rbank=0.
  - rd_data=0, rd_data_valid=0, err=0.
  - Storage contents are not reset.
- wr_ready = (state[wbank]==FREE), combinational from registered state.
- rd_avail = (state[rbank]==FULL).
- bank_full_cnt = count of FULL banks; registered or combinational from state; 0 after reset.
- Write:
  - wr_en & wr_ready & wr_addr<DEPTH stores wr_data at bank wbank on the clock edge.
  - Otherwise the write is dropped.
  - wr_en with !wr_ready, or with wr_addr>=DEPTH, sets err.
- Commit:
  - wr_commit & wr_ready: state[wbank] becomes FULL and wbank toggles at the same edge.
  - A write in the same cycle as the commit lands in the bank being committed.
  - wr_commit with !wr_ready is ignored and sets err.
- Read:
  - rd_en & rd_avail: rd_data <= bank[rbank][rd_addr] at the next edge; rd_data_valid=1 for exactly that cycle. Latency is 1 clock.
  - rd_addr>=DEPTH returns 0 with valid=1 and sets err.
  - rd_en with !rd_avail: rd_data holds its value, valid=0, err set.
  - With no rd_en, rd_data holds and valid=0.
- Release:
  - rd_release & rd_avail: state[rbank] becomes FREE and rbank toggles.
  - A read issued in the same cycle as the release still returns data from the released bank.
  - rd_release with !rd_avail is ignored and sets err.
- Simultaneous events:
  - commit and release in the same cycle always target different banks or are individually validated; both take effect.
  - bank_full_cnt is unchanged when both fire.
- Both banks FULL: wr_ready=0, producer must stall.
- Both banks FREE: rd_avail=0.
- Read and write never alias the same bank, because a bank is only FREE (writer) or FULL (reader). No read-during-write hazard exists.
- Pointer wrap: the 1-bit pointers toggle 0->1->0 indefinitely. Banks are consumed in commit order (FIFO of depth 2).
- err clears only on reset.
- Reset mid-operation discards all ownership: both banks FREE, pending read output cleared to 0/valid 0.

Test Plan:
- Reset, then idle: wr_ready=1, rd_avail=0, bank_full_cnt=0, rd_data=0, err=0.
- Write addr0..191 with data=addr, commit, then read addr 5 -> rd_data=0x05 with valid one cycle after rd_en; rd_avail=1, bank_full_cnt=1.
- Fill and commit bank0 (data 0xA0+addr), fill bank1 (0xB0+addr) while reading bank0:
  - after the second commit, wr_ready=0 and bank_full_cnt=2.
  - release bank0, then read addr3 -> 0xB3.
- Same-cycle commit (bank1) and release (bank0) with bank0 FULL: afterwards bank_full_cnt=1, rd_avail=1 on bank1, wr_ready=1 on bank0.
- Protocol errors:
  - rd_en with rd_avail=0 -> valid=0 and err=1.
  - wr_en with wr_addr=200 -> no write, err=1.
  - err stays 1 until reset_n pulses low.
- Assert reset_n low mid-read (valid pending) -> rd_data_valid=0 and rd_data=0 immediately; both banks FREE, wr_ready=1.
